// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the slide-switch debouncer.
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH              = 8;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;
  localparam int unsigned CLK_HZ                = 100000000;

  // Per-edge decision taken by one bit's stability counter.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_RUN,
    CNT_ACCEPT
  } cnt_action_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced level and change pulse.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic changed
);

  localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cnt_action_e      action;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= din;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    if (s2_q == stable_q)       action = CNT_HOLD;
    else if (cnt_q == CNT_LAST) action = CNT_ACCEPT;
    else                        action = CNT_RUN;
  end

  // Any return to the current level clears the count, so glitches never accumulate.
  always_comb begin
    stable_d  = stable_q;
    changed_d = 1'b0;
    cnt_d     = '0;
    case (action)
      CNT_RUN:    cnt_d = cnt_q + CNT_W'(1);
      CNT_ACCEPT: begin
        stable_d  = s2_q;
        changed_d = 1'b1;
      end
      default:    cnt_d = '0;
    endcase
  end

  assign dout    = stable_q;
  assign changed = changed_q;

endmodule

// File: rtl/switch_debounce.sv
// Switch-bank debouncer: WIDTH independent debounce_bit slices.
// Optional event register enabled by SWITCH_DEBOUNCE_EVENT_EN.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = SW_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed
`ifdef SWITCH_DEBOUNCE_EVENT_EN
  ,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] evt_value
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (switch[i]),
      .dout   (sw_stable[i]),
      .changed(sw_changed[i])
    );
  end

`ifdef SWITCH_DEBOUNCE_EVENT_EN
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_mask_q,  evt_mask_d;
  logic [WIDTH-1:0] evt_value_q, evt_value_d;
  logic             new_chg;
  logic             handshake;

  assign new_chg   = |sw_changed;
  assign handshake = evt_valid_q && evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_mask_q  <= '0;
      evt_value_q <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_mask_q  <= evt_mask_d;
      evt_value_q <= evt_value_d;
    end
  end

  // Unaccepted changes merge into the pending mask; an accept on the same edge
  // as a new change starts a fresh event carrying only the new bits.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_mask_d  = evt_mask_q;
    evt_value_d = evt_value_q;
    if (!evt_valid_q || handshake) begin
      if (new_chg) begin
        evt_valid_d = 1'b1;
        evt_mask_d  = sw_changed;
        evt_value_d = sw_stable;
      end else begin
        evt_valid_d = 1'b0;
        evt_mask_d  = '0;
      end
    end else if (new_chg) begin
      evt_mask_d  = evt_mask_q | sw_changed;
      evt_value_d = sw_stable;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_mask  = evt_mask_q;
  assign evt_value = evt_value_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with STABLE_CYCLES=4, WIDTH=8.
module tb_switch_debounce;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 4;

  typedef struct {
    int           at_edge;
    logic [W-1:0] chg;
    logic [W-1:0] stab;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] switch;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_changed;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_mask;
  logic [W-1:0] evt_value;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  switch_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch    (switch),
    .sw_stable (sw_stable),
    .sw_changed(sw_changed)
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    ,
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_mask  (evt_mask),
    .evt_value (evt_value)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at_edge, input logic [W-1:0] chg, input logic [W-1:0] stab);
    exp_t e;
    e.at_edge = at_edge;
    e.chg     = chg;
    e.stab    = stab;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    switch = 8'hFF;
    rst_n  = 1'b0;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    evt_ready = 1'b0;
`endif

    // Monitor: every sw_changed pulse must match the head of the expectation queue.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (sw_changed != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pulse actual=%0h required=0 edge=%0d", sw_changed, edge_cnt);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_edge",    edge_cnt,   e.at_edge);
            chk("pulse_changed", sw_changed, e.chg);
            chk("pulse_stable",  sw_stable,  e.stab);
          end
        end else if (exp_q.size() != 0 && exp_q[0].at_edge < edge_cnt) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL pulse_missing actual=none required=%0h at_edge=%0d", e.chg, e.at_edge);
        end
      end
    join_none

    // Switches held high through reset.
    repeat (3) step();
    chk("reset_stable",  sw_stable,  0);
    chk("reset_changed", sw_changed, 0);
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    chk("reset_evt_valid", evt_valid, 0);
`endif
    rst_n = 1'b1;
    n = edge_cnt;
    expect_pulse(n + 6, 8'hFF, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("release_hold_low", sw_stable, 8'h00);
    end
    step();
    step();
    chk("release_pulse_once", sw_changed, 8'h00);
    chk("release_stable_high", sw_stable, 8'hFF);

    rst_n  = 1'b0;
    switch = 8'h00;
    step();
    rst_n = 1'b1;
    step();

    // Clean rise on bit 0.
    switch = 8'h01;
    n = edge_cnt;
    expect_pulse(n + 6, 8'h01, 8'h01);
    repeat (8) step();

    // Three-cycle glitch on bit 3 is rejected.
    switch = 8'h09;
    repeat (3) step();
    switch = 8'h01;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch_hold", sw_stable, 8'h01);
    end

    // Bit 1 bouncing every 2 cycles, then settling high.
    for (int k = 0; k < 20; k++) begin
      switch[1] = (k % 2 == 0);
      repeat (2) begin
        step();
        chk("bounce_hold", sw_stable, 8'h01);
      end
    end
    switch[1] = 1'b1;
    n = edge_cnt;
    expect_pulse(n + 6, 8'h02, 8'h03);
    repeat (8) step();

    // Asynchronous reset with bit 4 counting (cnt=2 after the fourth edge).
    switch = 8'h13;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stable",  sw_stable,  8'h00);
    chk("async_rst_changed", sw_changed, 8'h00);
    switch = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("post_rst_stable", sw_stable, 8'h00);

`ifdef SWITCH_DEBOUNCE_EVENT_EN
    evt_ready = 1'b0;
    switch = 8'h04;
    n = edge_cnt;
    expect_pulse(n + 6, 8'h04, 8'h04);
    repeat (8) step();
    chk("evt1_valid", evt_valid, 1);
    chk("evt1_mask",  evt_mask,  8'h04);
    chk("evt1_value", evt_value, 8'h04);
    switch = 8'h24;
    n = edge_cnt;
    expect_pulse(n + 6, 8'h20, 8'h24);
    repeat (8) step();
    chk("evt2_valid", evt_valid, 1);
    chk("evt2_mask",  evt_mask,  8'h24);
    chk("evt2_value", evt_value, 8'h24);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("evt_accept_valid", evt_valid, 0);
    chk("evt_accept_mask",  evt_mask,  8'h00);
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
